// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage of the 5-stage pipeline.
//
// Holds the architectural fetch PC, drives a request/ready handshake to
// instruction memory (arbitrary wait states) and owns the IF/ID register.
// Supports a hazard-unit stall and a branch/jump redirect from later stages.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   imem_addr/req    fetch address and request to instruction memory
//   imem_ready/data  memory response; data valid for imem_addr when ready
//   stall            hold IF/ID contents
//   redirect(_pc)    flush IF/ID and refetch from redirect_pc
//   instruction_out  IF/ID instruction
//   nextPC_out       IF/ID PC+4 of instruction_out
//   valid_out        IF/ID holds a real instruction
module instruction_fetch #(
  parameter int unsigned     SIZE      = 32,
  parameter logic [0:SIZE-1] RESET_PC  = 32'h0000_0000,
  parameter logic [0:SIZE-1] NOP_INSTR = 32'h5400_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic [0:SIZE-1] imem_addr,
  output logic            imem_req,
  input  logic            imem_ready,
  input  logic [0:SIZE-1] imem_data,
  input  logic            stall,
  input  logic            redirect,
  input  logic [0:SIZE-1] redirect_pc,
  output logic [0:SIZE-1] instruction_out,
  output logic [0:SIZE-1] nextPC_out,
  output logic            valid_out
);

  // StHold: a returned word is parked in the buffer while decode stalls.
  // StDiscard: a redirect arrived mid-wait; the outstanding word is dropped.
  typedef enum logic [1:0] {StFetch, StHold, StDiscard} state_e;

  state_e          state_q, state_d;
  logic [0:SIZE-1] fetch_pc_q, fetch_pc_d;
  logic [0:SIZE-1] target_pc_q, target_pc_d;
  logic [0:SIZE-1] buf_instr_q, buf_instr_d;
  logic [0:SIZE-1] buf_npc_q, buf_npc_d;
  logic [0:SIZE-1] instr_q, instr_d;
  logic [0:SIZE-1] npc_q, npc_d;
  logic            valid_q, valid_d;
  logic [0:SIZE-1] pc_plus4;

  assign pc_plus4 = fetch_pc_q + SIZE'(4);

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    target_pc_d = target_pc_q;
    buf_instr_d = buf_instr_q;
    buf_npc_d   = buf_npc_q;
    instr_d     = instr_q;
    npc_d       = npc_q;
    valid_d     = valid_q;

    unique case (state_q)
      StFetch: begin
        if (imem_ready) begin
          if (redirect) begin
            fetch_pc_d = redirect_pc;
            instr_d    = NOP_INSTR;
            valid_d    = 1'b0;
          end else if (!stall) begin
            instr_d    = imem_data;
            npc_d      = pc_plus4;
            valid_d    = 1'b1;
            fetch_pc_d = pc_plus4;
          end else begin
            buf_instr_d = imem_data;
            buf_npc_d   = pc_plus4;
            fetch_pc_d  = pc_plus4;
            state_d     = StHold;
          end
        end else if (redirect) begin
          // Keep fetch_pc so imem_addr stays stable until the pending ready.
          target_pc_d = redirect_pc;
          instr_d     = NOP_INSTR;
          valid_d     = 1'b0;
          state_d     = StDiscard;
        end else if (!stall) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end

      StHold: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          instr_d    = NOP_INSTR;
          valid_d    = 1'b0;
          state_d    = StFetch;
        end else if (!stall) begin
          instr_d = buf_instr_q;
          npc_d   = buf_npc_q;
          valid_d = 1'b1;
          state_d = StFetch;
        end
      end

      StDiscard: begin
        if (redirect) target_pc_d = redirect_pc;
        if (imem_ready) begin
          fetch_pc_d = redirect ? redirect_pc : target_pc_q;
          state_d    = StFetch;
        end
        if (redirect || !stall) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end

      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFetch;
      fetch_pc_q  <= RESET_PC;
      target_pc_q <= '0;
      buf_instr_q <= '0;
      buf_npc_q   <= '0;
      instr_q     <= NOP_INSTR;
      npc_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      target_pc_q <= target_pc_d;
      buf_instr_q <= buf_instr_d;
      buf_npc_q   <= buf_npc_d;
      instr_q     <= instr_d;
      npc_q       <= npc_d;
      valid_q     <= valid_d;
    end
  end

  assign imem_addr       = fetch_pc_q;
  assign imem_req        = !reset && (state_q == StFetch || state_q == StDiscard);
  assign instruction_out = instr_q;
  assign nextPC_out      = npc_q;
  assign valid_out       = valid_q;

endmodule
